// File: rtl/aes_ghash_accum.sv
// aes_ghash_accum
// GHASH accumulation stage of the AES-GCM pipeline. For one GCM instance it
// folds each ciphertext block into the running hash, X_i = (X_{i-1} ^ C_i) * H
// in GF(2^128). The multiply is digit-serial: DIGIT operand bits are handled
// per cycle, so one block takes N = 128/DIGIT cycles. When the last block of an
// instance is done, o_sblock holds the final X and o_ready pulses for one
// cycle. The tag stage then folds in the length block and E(K,J0).
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   i_valid            a block beat is offered
//   i_first / i_last   beat opens / closes an instance (both may be set)
//   i_cipher_text      ciphertext block C_i (bit 0 = x^0 coefficient)
//   i_h                hash subkey H, sampled on a first beat
//   i_instance_size    len(A)||len(C) block, sampled on a first beat
//   i_encrypted_j0     E(K,J0), sampled on a first beat
//   o_in_ready         beat accepted on an edge where i_valid && o_in_ready
//   o_cipher_text      last accepted C_i
//   o_sblock           X of the last completed multiply
//   o_h, o_instance_size, o_encrypted_j0   values latched on the first beat
//   o_ready            one-cycle pulse: o_sblock is the final X of the instance
//   o_seq_err          one-cycle pulse: a non-first beat arrived with no open instance
module aes_ghash_accum #(
  parameter int DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic         i_first,
  input  logic         i_last,
  input  logic [0:127] i_cipher_text,
  input  logic [0:127] i_h,
  input  logic [0:127] i_instance_size,
  input  logic [0:127] i_encrypted_j0,
  output logic         o_in_ready,
  output logic [0:127] o_cipher_text,
  output logic [0:127] o_sblock,
  output logic [0:127] o_h,
  output logic [0:127] o_instance_size,
  output logic [0:127] o_encrypted_j0,
  output logic         o_ready,
  output logic         o_seq_err
);

  localparam int N     = 128 / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  // Reduction polynomial in GCM bit order: bits 0,1,2,7 set.
  localparam logic [0:127] R = {8'hE1, 120'b0};

  typedef enum logic [1:0] {IDLE, OPEN, MULT} state_t;

  state_t           state;
  state_t           state_next;
  logic [0:127]     x_op;
  logic [0:127]     z;
  logic [0:127]     v;
  logic [0:127]     z_step;
  logic [0:127]     v_step;
  logic [CNT_W-1:0] cnt;
  logic             last_flag;
  logic             accept;
  logic             mult_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, accept and in-ready. A non-first beat in IDLE is accepted
  // (and discarded) so the sender is never stalled by a sequencing error.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mult_done  = 1'b0;
    o_in_ready = 1'b0;
    case (state)
      IDLE: begin
        o_in_ready = 1'b1;
        accept     = i_valid;
        if (i_valid && i_first) begin
          state_next = MULT;
        end
      end
      OPEN: begin
        o_in_ready = 1'b1;
        accept     = i_valid;
        if (i_valid) begin
          state_next = MULT;
        end
      end
      MULT: begin
        if (cnt == CNT_LAST) begin
          mult_done  = 1'b1;
          state_next = last_flag ? IDLE : OPEN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One digit of the shift-and-add multiply. The operand register is shifted
  // toward bit 0 every cycle, so the current digit always sits in bits
  // [0:DIGIT-1] and is consumed in ascending index order.
  always_comb begin
    z_step = z;
    v_step = v;
    for (int j = 0; j < DIGIT; j++) begin
      if (x_op[j]) begin
        z_step = z_step ^ v_step;
      end
      v_step = v_step[127] ? ((v_step >> 1) ^ R) : (v_step >> 1);
    end
  end

  // Datapath and registered outputs. o_sblock only moves on the final
  // multiply cycle, so it stays stable while a block is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_op            <= '0;
      z               <= '0;
      v               <= '0;
      cnt             <= '0;
      last_flag       <= 1'b0;
      o_cipher_text   <= '0;
      o_sblock        <= '0;
      o_h             <= '0;
      o_instance_size <= '0;
      o_encrypted_j0  <= '0;
      o_ready         <= 1'b0;
      o_seq_err       <= 1'b0;
    end else begin
      o_ready   <= 1'b0;
      o_seq_err <= 1'b0;
      if (accept) begin
        o_cipher_text <= i_cipher_text;
        last_flag     <= i_last;
        z             <= '0;
        cnt           <= '0;
        if (i_first) begin
          o_h             <= i_h;
          o_instance_size <= i_instance_size;
          o_encrypted_j0  <= i_encrypted_j0;
          x_op            <= i_cipher_text;
          v               <= i_h;
        end else if (state == OPEN) begin
          x_op <= o_sblock ^ i_cipher_text;
          v    <= o_h;
        end else begin
          o_seq_err <= 1'b1;
        end
      end else if (state == MULT) begin
        z    <= z_step;
        v    <= v_step;
        x_op <= x_op << DIGIT;
        cnt  <= cnt + 1'b1;
        if (mult_done) begin
          o_sblock <= z_step;
          o_ready  <= last_flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_ghash_accum.sv
// tb_aes_ghash_accum
// Drives three copies of aes_ghash_accum (DIGIT = 1, 8, 128) one at a time
// through the same plan. A reference GF(2^128) model predicts every result;
// final S-blocks are queued when the last beat is driven and popped when the
// selected copy raises o_ready.
module tb_aes_ghash_accum;

  localparam int BUDGET = 400;
  localparam logic [0:127] H1    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] C1    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] S1    = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [0:127] LEN1  = 128'h00000000000000000000000000000080;
  localparam logic [0:127] J01   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [0:127] H_ONE = 128'h80000000000000000000000000000000;
  localparam logic [0:127] RPOLY = {8'hE1, 120'b0};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_first = 1'b0;
  logic         i_last = 1'b0;
  logic [0:127] i_cipher_text = '0;
  logic [0:127] i_h = '0;
  logic [0:127] i_instance_size = '0;
  logic [0:127] i_encrypted_j0 = '0;
  int           sel = 0;

  logic         valid_w [3];
  logic         in_ready_w [3];
  logic         ready_w [3];
  logic         seq_err_w [3];
  logic [0:127] cipher_w [3];
  logic [0:127] sblock_w [3];
  logic [0:127] h_w [3];
  logic [0:127] len_w [3];
  logic [0:127] j0_w [3];

  logic         cur_in_ready, cur_ready, cur_seq_err;
  logic [0:127] cur_cipher, cur_sblock, cur_h, cur_len, cur_j0;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int ready_count = 0;
  int seq_count = 0;
  int exp_ready = 0;
  int exp_seq = 0;

  logic         m_open = 1'b0;
  logic [0:127] m_x = '0;
  logic [0:127] m_h = '0;
  logic [0:127] exp_sblock = '0;
  logic [0:127] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      valid_w[k] = i_valid && (sel == k);
    end
  end

  always_comb begin
    cur_in_ready = in_ready_w[sel];
    cur_ready    = ready_w[sel];
    cur_seq_err  = seq_err_w[sel];
    cur_cipher   = cipher_w[sel];
    cur_sblock   = sblock_w[sel];
    cur_h        = h_w[sel];
    cur_len      = len_w[sel];
    cur_j0       = j0_w[sel];
  end

  aes_ghash_accum #(.DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .i_valid(valid_w[0]), .i_first(i_first), .i_last(i_last),
    .i_cipher_text(i_cipher_text), .i_h(i_h), .i_instance_size(i_instance_size),
    .i_encrypted_j0(i_encrypted_j0), .o_in_ready(in_ready_w[0]),
    .o_cipher_text(cipher_w[0]), .o_sblock(sblock_w[0]), .o_h(h_w[0]),
    .o_instance_size(len_w[0]), .o_encrypted_j0(j0_w[0]),
    .o_ready(ready_w[0]), .o_seq_err(seq_err_w[0])
  );

  aes_ghash_accum #(.DIGIT(8)) dut_d8 (
    .clk(clk), .rst(rst), .i_valid(valid_w[1]), .i_first(i_first), .i_last(i_last),
    .i_cipher_text(i_cipher_text), .i_h(i_h), .i_instance_size(i_instance_size),
    .i_encrypted_j0(i_encrypted_j0), .o_in_ready(in_ready_w[1]),
    .o_cipher_text(cipher_w[1]), .o_sblock(sblock_w[1]), .o_h(h_w[1]),
    .o_instance_size(len_w[1]), .o_encrypted_j0(j0_w[1]),
    .o_ready(ready_w[1]), .o_seq_err(seq_err_w[1])
  );

  aes_ghash_accum #(.DIGIT(128)) dut_d128 (
    .clk(clk), .rst(rst), .i_valid(valid_w[2]), .i_first(i_first), .i_last(i_last),
    .i_cipher_text(i_cipher_text), .i_h(i_h), .i_instance_size(i_instance_size),
    .i_encrypted_j0(i_encrypted_j0), .o_in_ready(in_ready_w[2]),
    .o_cipher_text(cipher_w[2]), .o_sblock(sblock_w[2]), .o_h(h_w[2]),
    .o_instance_size(len_w[2]), .o_encrypted_j0(j0_w[2]),
    .o_ready(ready_w[2]), .o_seq_err(seq_err_w[2])
  );

  function automatic int n_of(input int s);
    case (s)
      0:       return 128;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // Bit-serial GF(2^128) product, bit 0 = x^0 coefficient.
  function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z = '0;
    logic [0:127] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      v = v[127] ? ((v >> 1) ^ RPOLY) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s (digit-sel %0d): got %h, expected %h", tag, sel, got, exp);
    end
  endtask

  // Final S-blocks, latency and overlap checks whenever the selected copy pulses.
  always @(negedge clk) begin
    if (cur_ready) begin
      ready_count++;
      if (exp_q.size() == 0) begin
        checkOutput("ready_unexpected", cur_ready, 0);
      end else begin
        checkOutput("sblock_final", cur_sblock, exp_q.pop_front());
        checkOutput("ready_latency", cyc - accept_cyc, n_of(sel));
      end
    end
    if (cur_seq_err) seq_count++;
    if (cur_ready || cur_seq_err) begin
      checkOutput("ready_seq_overlap", cur_ready & cur_seq_err, 0);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sblock"}, cur_sblock, 0);
    checkOutput({tag, "_cipher"}, cur_cipher, 0);
    checkOutput({tag, "_h"}, cur_h, 0);
    checkOutput({tag, "_len"}, cur_len, 0);
    checkOutput({tag, "_j0"}, cur_j0, 0);
    checkOutput({tag, "_in_ready"}, cur_in_ready, 1);
    checkOutput({tag, "_ready"}, cur_ready, 0);
    checkOutput({tag, "_seq_err"}, cur_seq_err, 0);
  endtask

  task automatic clearModel();
    m_open     = 1'b0;
    m_x        = '0;
    exp_sblock = '0;
    exp_q.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clearModel();
    checkResetState("reset");
    rst = 1'b0;
  endtask

  // Offers one beat, updates the model, waits for acceptance and then counts
  // the cycles o_in_ready stays low. With keep set, i_valid stays high so the
  // caller can chain the next beat in the first ready cycle.
  task automatic applyStimulus(input logic first, input logic last, input logic [0:127] c,
                               input logic [0:127] h, input logic [0:127] len,
                               input logic [0:127] j0, input logic keep, output int low);
    int waited = 0;
    i_valid = 1'b1;
    i_first = first;
    i_last = last;
    i_cipher_text = c;
    i_h = h;
    i_instance_size = len;
    i_encrypted_j0 = j0;
    if (first) begin
      m_h = h;
      m_x = gf_mul(c, h);
      exp_sblock = m_x;
      if (last) begin
        exp_q.push_back(m_x);
        exp_ready++;
      end
      m_open = !last;
    end else if (m_open) begin
      m_x = gf_mul(m_x ^ c, m_h);
      exp_sblock = m_x;
      if (last) begin
        exp_q.push_back(m_x);
        exp_ready++;
        m_open = 1'b0;
      end
    end else begin
      exp_seq++;
    end
    low = 0;
    while (!cur_in_ready && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!cur_in_ready) begin
      checkOutput("accept_timeout", cur_in_ready, 1);
      i_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      accept_cyc = cyc;
      if (!keep) i_valid = 1'b0;
      while (!cur_in_ready && low < BUDGET) begin
        low++;
        @(negedge clk);
      end
    end
  endtask

  task automatic runPlan();
    int n;
    int low, low2, low3;
    logic [0:127] a, b, c;
    n = n_of(sel);
    doReset();

    // Known-answer single block.
    applyStimulus(1, 1, C1, H1, LEN1, J01, 0, low);
    idle(2);
    checkOutput("kat_low_cycles", low, n);
    checkOutput("kat_ready_count", ready_count, exp_ready);
    checkOutput("kat_sblock", cur_sblock, S1);
    checkOutput("kat_len", cur_len, LEN1);
    checkOutput("kat_j0", cur_j0, J01);
    checkOutput("kat_h", cur_h, H1);
    checkOutput("kat_cipher", cur_cipher, C1);

    // Identity and zero subkey.
    a = rand128();
    b = rand128();
    applyStimulus(1, 0, a, H_ONE, rand128(), rand128(), 0, low);
    applyStimulus(0, 1, b, rand128(), rand128(), rand128(), 0, low);
    idle(2);
    checkOutput("identity_sblock", cur_sblock, a ^ b);
    applyStimulus(1, 1, a, '0, rand128(), rand128(), 0, low);
    idle(2);
    checkOutput("zero_h_sblock", cur_sblock, 0);

    // Back-to-back three-beat instance with i_valid held high.
    applyStimulus(1, 0, rand128(), rand128(), rand128(), rand128(), 1, low);
    applyStimulus(0, 0, rand128(), rand128(), rand128(), rand128(), 1, low2);
    applyStimulus(0, 1, rand128(), rand128(), rand128(), rand128(), 0, low3);
    idle(2);
    checkOutput("b2b_low1", low, n);
    checkOutput("b2b_low2", low2, n);
    checkOutput("b2b_low3", low3, n);
    checkOutput("b2b_ready_count", ready_count, exp_ready);
    checkOutput("b2b_sblock", cur_sblock, exp_sblock);

    // Non-first beat with no open instance.
    c = rand128();
    applyStimulus(0, 1, c, rand128(), rand128(), rand128(), 0, low);
    idle(3);
    checkOutput("seq_low_cycles", low, 0);
    checkOutput("seq_err_count", seq_count, exp_seq);
    checkOutput("seq_ready_count", ready_count, exp_ready);
    checkOutput("seq_sblock_held", cur_sblock, exp_sblock);
    checkOutput("seq_cipher", cur_cipher, c);

    // Restart an open instance with a fresh first beat.
    applyStimulus(1, 0, rand128(), rand128(), rand128(), rand128(), 0, low);
    applyStimulus(1, 1, C1, H1, LEN1, J01, 0, low);
    idle(2);
    checkOutput("restart_ready_count", ready_count, exp_ready);
    checkOutput("restart_sblock", cur_sblock, S1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    i_valid = 1'b1;
    i_first = 1'b1;
    i_last = 1'b1;
    i_cipher_text = rand128();
    i_h = rand128();
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    checkOutput("abort_in_mult", cur_in_ready, 0);
    idle(n / 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clearModel();
    checkResetState("abort");
    rst = 1'b0;
    idle(n + 3);
    checkOutput("abort_ready_count", ready_count, exp_ready);
    checkOutput("abort_sblock", cur_sblock, 0);
    applyStimulus(1, 1, C1, H1, LEN1, J01, 0, low);
    idle(2);
    checkOutput("rerun_ready_count", ready_count, exp_ready);
    checkOutput("rerun_sblock", cur_sblock, S1);
    checkOutput("rerun_len", cur_len, LEN1);
    checkOutput("rerun_j0", cur_j0, J01);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      sel = s;
      ready_count = 0;
      seq_count = 0;
      exp_ready = 0;
      exp_seq = 0;
      runPlan();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, failed);
    $fatal(1, "[TB] watchdog");
  end

endmodule
